// File: rtl/fp_align_stage.sv
// FP32 adder align/add stage: accepts an operand pair, aligns the smaller mantissa by
// iterative right shifts with guard/round/sticky tracking, then adds or subtracts.
module fp_align_stage #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [23:0] aligned_result,
    output logic        aligned_sign,
    output logic [7:0]  exponent_out,
    output logic        carry_out,
    output logic        guard_bit,
    output logic        round_bit,
    output logic        sticky_bit
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ADD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] STEP_MAX = 8'(SHIFT_PER_CYCLE);

    logic [1:0]  state;
    logic        l_sign;
    logic        s_sign;
    logic [7:0]  l_exp;
    logic [23:0] l_mant;
    logic [26:0] s_ext;      // {mant24, guard, round, sticky}
    logic [7:0]  remaining;
    logic        special;

    logic        a_hid, b_hid;
    logic [7:0]  a_eff, b_eff;
    logic        a_ge_b;
    logic        in_special;
    logic [7:0]  diff;
    logic [7:0]  step;
    logic [26:0] lost_mask;
    logic [26:0] shifted;
    logic [24:0] sum25;
    logic [26:0] sub27;

    always_comb begin
        a_hid      = |a[30:23];
        b_hid      = |b[30:23];
        a_eff      = a_hid ? a[30:23] : 8'd1;
        b_eff      = b_hid ? b[30:23] : 8'd1;
        a_ge_b     = (a[30:0] >= b[30:0]);
        in_special = (&a[30:23]) | (&b[30:23]);
        diff       = a_ge_b ? (a_eff - b_eff) : (b_eff - a_eff);

        step      = (remaining < STEP_MAX) ? remaining : STEP_MAX;
        lost_mask = (27'd1 << step) - 27'd1;
        // anything shifted past the sticky position folds back into sticky
        shifted   = (s_ext >> step) | {26'd0, |(s_ext & lost_mask)};

        sum25 = {1'b0, l_mant} + {1'b0, s_ext[26:3]};
        sub27 = {l_mant, 3'b000} - s_ext;
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            l_sign         <= 1'b0;
            s_sign         <= 1'b0;
            l_exp          <= 8'd0;
            l_mant         <= 24'd0;
            s_ext          <= 27'd0;
            remaining      <= 8'd0;
            special        <= 1'b0;
            a_out          <= 32'd0;
            b_out          <= 32'd0;
            aligned_result <= 24'd0;
            aligned_sign   <= 1'b0;
            exponent_out   <= 8'd0;
            carry_out      <= 1'b0;
            guard_bit      <= 1'b0;
            round_bit      <= 1'b0;
            sticky_bit     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_out     <= a;
                        b_out     <= b;
                        special   <= in_special;
                        remaining <= in_special ? 8'd0 : diff;
                        if (a_ge_b) begin
                            l_sign <= a[31];
                            l_exp  <= a[30:23];
                            l_mant <= {a_hid, a[22:0]};
                            s_sign <= b[31];
                            s_ext  <= {b_hid, b[22:0], 3'b000};
                        end else begin
                            l_sign <= b[31];
                            l_exp  <= b[30:23];
                            l_mant <= {b_hid, b[22:0]};
                            s_sign <= a[31];
                            s_ext  <= {a_hid, a[22:0], 3'b000};
                        end
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (remaining == 8'd0) begin
                        state <= ST_ADD;
                    end else if (remaining >= 8'd27) begin
                        s_ext     <= {26'd0, |s_ext};
                        remaining <= 8'd0;
                    end else begin
                        s_ext     <= shifted;
                        remaining <= remaining - step;
                    end
                end
                ST_ADD: begin
                    exponent_out <= special ? 8'hFF : l_exp;
                    if (l_sign == s_sign) begin
                        {carry_out, aligned_result} <= sum25;
                        {guard_bit, round_bit, sticky_bit} <= s_ext[2:0];
                        aligned_sign <= l_sign;
                    end else begin
                        {aligned_result, guard_bit, round_bit, sticky_bit} <= sub27;
                        carry_out    <= 1'b0;
                        aligned_sign <= (sub27 == 27'd0) ? 1'b0 : l_sign;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed-vector bench for fp_align_stage; a second instance with SHIFT_PER_CYCLE=4
// covers the multi-bit shift latency.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic        in_ready1, out_valid1;
    logic [31:0] a_out1, b_out1;
    logic [23:0] res1;
    logic        sign1, carry1, g1, r1, s1;
    logic [7:0]  exp1;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4;
    logic [31:0] a_out4, b_out4;
    logic [23:0] res4;
    logic        sign4, carry4, g4, r4, s4;
    logic [7:0]  exp4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_align_stage #(.SHIFT_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(op_a), .b(op_b), .out_valid(out_valid1), .out_ready(out_ready1),
        .a_out(a_out1), .b_out(b_out1), .aligned_result(res1), .aligned_sign(sign1),
        .exponent_out(exp1), .carry_out(carry1), .guard_bit(g1), .round_bit(r1),
        .sticky_bit(s1)
    );

    fp_align_stage #(.SHIFT_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(op_a), .b(op_b), .out_valid(out_valid4), .out_ready(out_ready4),
        .a_out(a_out4), .b_out(b_out4), .aligned_result(res4), .aligned_sign(sign4),
        .exponent_out(exp4), .carry_out(carry4), .guard_bit(g4), .round_bit(r4),
        .sticky_bit(s4)
    );

    // packed {carry, result, sign, exponent, g, r, s}
    wire [36:0] pk1 = {carry1, res1, sign1, exp1, g1, r1, s1};
    wire [36:0] pk4 = {carry4, res4, sign4, exp4, g4, r4, s4};

    // Presents one operand pair, waits for accept, counts edges until out_valid.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input bit use4,
                            output int lat);
        @(negedge clk);
        op_a = ta;
        op_b = tb;
        if (use4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (use4 ? out_valid4 : out_valid1) break;
        end
        total++;
        if (lat >= 100) begin
            bad++;
            $display("FAIL timeout waiting for out_valid: got %0d cycles, need < 100", lat);
        end
    endtask

    task automatic take_result(input bit use4);
        if (use4) out_ready4 = 1'b1; else out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready1, out_valid1, a_out1, b_out1, pk1} !== {1'b1, 1'b0, 32'd0, 32'd0, 37'd0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b a=%h b=%h pk=%h, need rdy=1 vld=0 all 0",
                     in_ready1, out_valid1, a_out1, b_out1, pk1);
        end
    endtask

    task automatic test_equal_add();
        int lat;
        start_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b1, 24'h000000, 1'b0, 8'h7F, 3'b000} || lat != 2) begin
            bad++;
            $display("FAIL equal_add: pk=%h lat=%0d, need pk=%h lat=2",
                     pk1, lat, {1'b1, 24'h000000, 1'b0, 8'h7F, 3'b000});
        end
        take_result(1'b0);
        total++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL release_ready: rdy=%b vld=%b, need 1 0", in_ready1, out_valid1);
        end
    endtask

    task automatic test_shift_one();
        int lat;
        start_op(32'h3F800000, 32'h3F000000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b0, 24'hC00000, 1'b0, 8'h7F, 3'b000} || lat != 3) begin
            bad++;
            $display("FAIL shift_one_spc1: pk=%h lat=%0d, need pk=%h lat=3",
                     pk1, lat, {1'b0, 24'hC00000, 1'b0, 8'h7F, 3'b000});
        end
        take_result(1'b0);
        start_op(32'h3F800000, 32'h3F000000, 1'b1, lat);
        total++;
        if (pk4 !== {1'b0, 24'hC00000, 1'b0, 8'h7F, 3'b000} || lat != 3) begin
            bad++;
            $display("FAIL shift_one_spc4: pk=%h lat=%0d, need pk=%h lat=3",
                     pk4, lat, {1'b0, 24'hC00000, 1'b0, 8'h7F, 3'b000});
        end
        take_result(1'b1);
    endtask

    task automatic test_cancel();
        int lat;
        start_op(32'h3F800000, 32'hBF800000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b0, 24'h000000, 1'b0, 8'h7F, 3'b000}) begin
            bad++;
            $display("FAIL cancel: pk=%h, need %h", pk1, {1'b0, 24'h000000, 1'b0, 8'h7F, 3'b000});
        end
        take_result(1'b0);
    endtask

    task automatic test_far_sticky();
        int lat;
        start_op(32'h3F800000, 32'h30800000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b0, 24'h800000, 1'b0, 8'h7F, 3'b001} || lat != 3) begin
            bad++;
            $display("FAIL far_sticky: pk=%h lat=%0d, need pk=%h lat=3",
                     pk1, lat, {1'b0, 24'h800000, 1'b0, 8'h7F, 3'b001});
        end
        take_result(1'b0);
    endtask

    // 2.0 - 0.75000006: B mant C00001 shifted by 2 leaves r=1, then borrow through grs.
    task automatic test_subtract_grs();
        int lat;
        start_op(32'h40000000, 32'hBF400001, 1'b0, lat);
        total++;
        if (pk1 !== {1'b0, 24'h4FFFFF, 1'b0, 8'h80, 3'b110} || lat != 4) begin
            bad++;
            $display("FAIL subtract_grs_spc1: pk=%h lat=%0d, need pk=%h lat=4",
                     pk1, lat, {1'b0, 24'h4FFFFF, 1'b0, 8'h80, 3'b110});
        end
        take_result(1'b0);
        start_op(32'h40000000, 32'hBF400001, 1'b1, lat);
        total++;
        if (pk4 !== {1'b0, 24'h4FFFFF, 1'b0, 8'h80, 3'b110} || lat != 3) begin
            bad++;
            $display("FAIL subtract_grs_spc4: pk=%h lat=%0d, need pk=%h lat=3",
                     pk4, lat, {1'b0, 24'h4FFFFF, 1'b0, 8'h80, 3'b110});
        end
        take_result(1'b1);
    endtask

    // B is the larger denormal, so it becomes L; negative sign of B carries through.
    task automatic test_denormal();
        int lat;
        start_op(32'h80000001, 32'h80000002, 1'b0, lat);
        total++;
        if (pk1 !== {1'b0, 24'h000003, 1'b1, 8'h00, 3'b000} || lat != 2) begin
            bad++;
            $display("FAIL denormal: pk=%h lat=%0d, need pk=%h lat=2",
                     pk1, lat, {1'b0, 24'h000003, 1'b1, 8'h00, 3'b000});
        end
        take_result(1'b0);
    endtask

    task automatic test_inf_hold();
        int lat;
        int errs;
        start_op(32'h7F800000, 32'h3F800000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b1, 24'h000000, 1'b0, 8'hFF, 3'b000} || a_out1 !== 32'h7F800000 ||
            b_out1 !== 32'h3F800000 || lat != 2) begin
            bad++;
            $display("FAIL inf: pk=%h a=%h b=%h lat=%0d, need pk=%h a=7f800000 b=3f800000 lat=2",
                     pk1, a_out1, b_out1, lat, {1'b1, 24'h000000, 1'b0, 8'hFF, 3'b000});
        end
        errs = 0;
        op_a = 32'h12345678;
        op_b = 32'h9ABCDEF0;
        in_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || a_out1 !== 32'h7F800000 ||
                pk1 !== {1'b1, 24'h000000, 1'b0, 8'hFF, 3'b000})
                errs++;
        end
        in_valid1 = 1'b0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_stable: %0d unstable cycles, need 0", errs);
        end
        take_result(1'b0);
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        @(negedge clk);
        op_a = 32'h3F800000;
        op_b = 32'h35800000;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid1, a_out1, b_out1, pk1} !== {1'b0, 32'd0, 32'd0, 37'd0}) begin
            bad++;
            $display("FAIL reset_mid_shift: vld=%b a=%h b=%h pk=%h, need all 0",
                     out_valid1, a_out1, b_out1, pk1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b, need 1", in_ready1);
        end
        start_op(32'h3F800000, 32'h35800000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b0, 24'h800008, 1'b0, 8'h7F, 3'b000} || lat != 22) begin
            bad++;
            $display("FAIL diff20_after_reset: pk=%h lat=%0d, need pk=%h lat=22",
                     pk1, lat, {1'b0, 24'h800008, 1'b0, 8'h7F, 3'b000});
        end
        take_result(1'b0);
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'h3F800000, 32'h3F000000, 1'b0, lat);
        take_result(1'b0);
        start_op(32'hC0000000, 32'hC0000000, 1'b0, lat);
        total++;
        if (pk1 !== {1'b1, 24'h000000, 1'b1, 8'h80, 3'b000} || a_out1 !== 32'hC0000000 || lat != 2) begin
            bad++;
            $display("FAIL back_to_back: pk=%h a=%h lat=%0d, need pk=%h a=c0000000 lat=2",
                     pk1, a_out1, lat, {1'b1, 24'h000000, 1'b1, 8'h80, 3'b000});
        end
        take_result(1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_equal_add();
        test_shift_one();
        test_cancel();
        test_far_sticky();
        test_subtract_grs();
        test_denormal();
        test_inf_hold();
        test_reset_mid_shift();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
